// File: rtl/bht_update_queue.sv
// Elastic FIFO carrying resolved branch outcomes to the BHT.
// resolve_i / bht_update_o are packed as {valid, pc[VLEN-1:0], taken}.
module bht_update_queue #(
  parameter int unsigned VLEN    = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DROP_CW = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               debug_mode_i,
  input  logic [VLEN+1:0]    resolve_i,
  input  logic               bht_ready_i,
  output logic [VLEN+1:0]    bht_update_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DROP_CW-1:0] drop_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VLEN-1:0]    pc_q [DEPTH];
  logic [DEPTH-1:0]   taken_q;
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [DROP_CW-1:0] drop_cnt_q;

  logic            res_valid;
  logic [VLEN-1:0] res_pc;
  logic            res_taken;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            out_valid;
  logic            is_full;
  logic            is_empty;
  logic            overflow;

  assign res_valid = resolve_i[VLEN+1];
  assign res_pc    = resolve_i[VLEN:1];
  assign res_taken = resolve_i[0];

  assign is_full   = (count_q == FULL);
  assign is_empty  = (count_q == '0);
  assign out_valid = !is_empty && !flush_i;

  assign push_req = res_valid && !debug_mode_i && !flush_i;
  assign pop      = out_valid && bht_ready_i;
  assign push     = push_req && (!is_full || pop);
  assign overflow = push_req && is_full && !pop;

  assign count_d = count_q + CW'(push) - CW'(pop);

  // Head is read straight from storage; no bypass of the incoming update.
  always_comb begin
    bht_update_o = '0;
    if (!is_empty) begin
      bht_update_o = {out_valid, pc_q[rd_ptr_q], taken_q[rd_ptr_q]};
    end
  end

  assign full_o     = is_full;
  assign empty_o    = is_empty;
  assign drop_cnt_o = drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      taken_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]    <= res_pc;
        taken_q[wr_ptr_q] <= res_taken;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Flush never counts as a drop since push_req is already masked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (overflow && !(&drop_cnt_q)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CW'(1);
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: scoreboard queue of expected
// {pc, taken} entries, popped whenever the DUT hands one to the BHT.
module tb_bht_update_queue;

  localparam int unsigned VLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DCW   = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            debug_mode_i;
  logic [VLEN+1:0] resolve_i;
  logic            bht_ready_i;
  logic [VLEN+1:0] bht_update_o;
  logic            full_o;
  logic            empty_o;
  logic [DCW-1:0]  drop_cnt_o;

  bht_update_queue #(
    .VLEN    (VLEN),
    .DEPTH   (DEPTH),
    .DROP_CW (DCW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .debug_mode_i (debug_mode_i),
    .resolve_i    (resolve_i),
    .bht_ready_i  (bht_ready_i),
    .bht_update_o (bht_update_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [VLEN:0]  sb [$];
  logic [DCW-1:0] m_drop;

  logic            rv;
  logic [VLEN-1:0] rpc;
  logic            rtk;

  assign resolve_i = {rv, rpc, rtk};

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs vs model at negedge, then advance model.
  task automatic cyc();
    logic mv;
    logic mpop;
    logic acc;
    @(negedge clk_i);
    mv = (sb.size() != 0) && !flush_i;
    chk("valid", 96'(bht_update_o[VLEN+1]), 96'(mv));
    chk("empty", 96'(empty_o), 96'(sb.size() == 0));
    chk("full", 96'(full_o), 96'(sb.size() == DEPTH));
    chk("drop", 96'(drop_cnt_o), 96'(m_drop));
    if (sb.size() != 0) begin
      chk("head", 96'(bht_update_o[VLEN:0]), 96'(sb[0]));
    end else begin
      chk("idle", 96'(bht_update_o[VLEN:0]), 96'(0));
    end
    mpop = mv && bht_ready_i;
    if (flush_i) begin
      sb.delete();
    end else begin
      acc = 1'b0;
      if (rv && !debug_mode_i) begin
        if (sb.size() < DEPTH || mpop) acc = 1'b1;
        else if (m_drop != '1) m_drop = m_drop + 1'b1;
      end
      if (mpop) void'(sb.pop_front());
      if (acc) sb.push_back({rpc, rtk});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [VLEN-1:0] pc, input logic tk);
    rv = 1'b1; rpc = pc; rtk = tk;
    cyc();
    rv = 1'b0; rpc = '0; rtk = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_v"}, 96'(bht_update_o), 96'(0));
    chk({tag, "_f"}, 96'(full_o), 96'(0));
    chk({tag, "_e"}, 96'(empty_o), 96'(1));
    chk({tag, "_d"}, 96'(drop_cnt_o), 96'(0));
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0;
    bht_ready_i = 1'b1; rv = 1'b0; rpc = '0; rtk = 1'b0;
    m_drop = '0;
    #12;
    chk_reset("rst");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // single push, one-cycle latency
    push(64'h8000_0010, 1'b1);
    chk("t1_lat", 96'(bht_update_o), 96'({1'b1, 64'h8000_0010, 1'b1}));
    idle(2);
    chk("t1_empty", 96'(empty_o), 96'(1));

    // debug mode blocks pushes, queue still drains
    bht_ready_i = 1'b0;
    push(64'h100, 1'b0);
    push(64'h104, 1'b1);
    debug_mode_i = 1'b1; bht_ready_i = 1'b1;
    push(64'h108, 1'b1);
    idle(2);
    debug_mode_i = 1'b0;
    chk("t5_empty", 96'(empty_o), 96'(1));
    chk("t5_drop", 96'(drop_cnt_o), 96'(0));

    // overflow with ready low
    bht_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) push(64'(i * 16), i[0]);
    idle(1);
    chk("t2_full", 96'(full_o), 96'(1));
    chk("t2_drop", 96'(drop_cnt_o), 96'(1));
    chk("t2_head", 96'(bht_update_o[VLEN:1]), 96'(64'h10));
    bht_ready_i = 1'b1;
    idle(5);

    // push+pop at full across pointer wrap
    bht_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(64'h2000 + 64'(i * 4), 1'b1);
    bht_ready_i = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      push(64'h3000 + 64'(i * 4), i[1]);
      chk("t3_full", 96'(full_o), 96'(1));
    end
    chk("t3_drop", 96'(drop_cnt_o), 96'(1));
    idle(5);

    // flush together with a push
    bht_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(64'h4000 + 64'(i * 4), 1'b0);
    flush_i = 1'b1;
    rv = 1'b1; rpc = 64'h4444; rtk = 1'b1;
    cyc();
    rv = 1'b0; flush_i = 1'b0;
    chk("t4_empty", 96'(empty_o), 96'(1));
    chk("t4_drop", 96'(drop_cnt_o), 96'(1));
    idle(2);

    // short random mix
    for (int i = 0; i < 200; i++) begin
      rv = 1'($urandom_range(0, 1));
      rpc = 64'($urandom);
      rtk = 1'($urandom_range(0, 1));
      bht_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 19) == 0);
      debug_mode_i = ($urandom_range(0, 9) == 0);
      cyc();
    end
    rv = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0;
    bht_ready_i = 1'b1;
    idle(5);

    // saturating drop counter
    bht_ready_i = 1'b0;
    for (int i = 0; i < 4 + 300; i++) push(64'h5000 + 64'(i), 1'b1);
    idle(1);
    chk("t6_sat", 96'(drop_cnt_o), 96'(255));
    rv = 1'b1; rpc = 64'h6000;
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset("t6_rst");
    rv = 1'b0;
    sb.delete();
    m_drop = '0;
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
